// File: rtl/game_pkg.sv
// Shared definitions for the match FSM and the per-player controllers.
// Contents: game state codes, player state codes, datapath widths and a clamped
// position-step helper.
package game_pkg;

    localparam int unsigned HEALTH_W  = 3;
    localparam int unsigned POS_W     = 10;
    localparam int unsigned POS_WIDE  = POS_W + 1;
    localparam int unsigned TIMER_W   = 8;

    typedef enum logic [2:0] {
        GsIdle      = 3'd0,
        GsCountdown = 3'd1,
        GsFight     = 3'd2,
        GsP1Win     = 3'd3,
        GsP2Win     = 3'd4,
        GsEq        = 3'd5
    } game_state_e;

    typedef enum logic [2:0] {
        PsIdle          = 3'd0,
        PsMoveFwd       = 3'd1,
        PsMoveBack      = 3'd2,
        PsAttackWindup  = 3'd3,
        PsAttackActive  = 3'd4,
        PsAttackRecover = 3'd5,
        PsHitstun       = 3'd6,
        PsDead          = 3'd7
    } player_state_e;

    // Move pos by amount (up = towards +x), computed one bit wider and clamped
    // to [lo, hi]; the subtract path checks before subtracting so it never wraps.
    function automatic logic [POS_W-1:0] pos_step(
        input logic [POS_W-1:0] pos,
        input logic             up,
        input int unsigned      amount,
        input int unsigned      lo,
        input int unsigned      hi
    );
        logic [POS_W:0] wide;
        logic [POS_W:0] amt_w;
        logic [POS_W:0] lo_w;
        logic [POS_W:0] hi_w;
        amt_w = POS_WIDE'(amount);
        lo_w  = POS_WIDE'(lo);
        hi_w  = POS_WIDE'(hi);
        if (up) begin
            wide = {1'b0, pos} + amt_w;
        end else if ({1'b0, pos} < lo_w + amt_w) begin
            wide = lo_w;
        end else begin
            wide = {1'b0, pos} - amt_w;
        end
        if (wide > hi_w) wide = hi_w;
        if (wide < lo_w) wide = lo_w;
        return wide[POS_W-1:0];
    endfunction

endpackage

// File: rtl/player_phase_timer.sv
// Down counter timing the attack phases and hitstun of one player.
// Ports:
//   clk, reset  frame clock, asynchronous active-high reset (count -> 0)
//   clear       synchronous return to 0 (round re-arm)
//   load        load load_value (wins over dec)
//   load_value  value loaded; a phase of N frames loads N-1
//   dec         count down by one, holding at 0
//   done        count is 0: the current phase ends this frame
module player_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/player_fsm.sv
// Per-player controller: turns buttons into movement and a timed attack,
// applies hits from the opponent, tracks health and death, and reports
// state/health/position back to the match FSM.
// Ports:
//   clk, reset     60 Hz frame clock, asynchronous active-high reset
//   game_state     match state (IDLE/COUNTDOWN re-arm, FIGHT runs, wins freeze)
//   btn_left/right movement buttons (synchronized, active-high)
//   btn_attack     attack button; only its rising edge starts an attack
//   btn_block      block button, used only when PLAYER_BLOCK_EN is defined
//   hit_in         one-frame pulse: opponent's active hitbox overlaps us
//   player_state   current state code
//   player_health  remaining health
//   pos_x          horizontal position
//   attack_active  high exactly while player_state is ATTACK_ACTIVE
// Build option: define PLAYER_BLOCK_EN to enable blocking (blockstun with no
// health loss and a 4-pixel push back).
module player_fsm
    import game_pkg::*;
#(
    parameter int unsigned SIDE       = 0,
    parameter int unsigned START_X    = 100,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned SPEED      = 2,
    parameter int unsigned MAX_HEALTH = 3,
    parameter int unsigned T_WINDUP   = 8,
    parameter int unsigned T_ACTIVE   = 4,
    parameter int unsigned T_RECOVER  = 12,
    parameter int unsigned T_HITSTUN  = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          game_state,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_attack,
    input  logic                btn_block,
    input  logic                hit_in,
    output logic [2:0]          player_state,
    output logic [HEALTH_W-1:0] player_health,
    output logic [POS_W-1:0]    pos_x,
    output logic                attack_active
);

    player_state_e       state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                attack_active_q;
    logic                atk_prev_q;

    logic                tmr_clear;
    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_load_value;
    logic                tmr_dec;
    logic                tmr_done;

    logic                atk_rise;
    logic                blocked;
    logic                move_fwd;

    assign atk_rise = btn_attack & ~atk_prev_q;

    // Forward is +x for the left player (SIDE 0) and -x for the right player.
    assign move_fwd = (SIDE == 0) ? btn_right : btn_left;

`ifdef PLAYER_BLOCK_EN
    assign blocked = btn_block &&
                     (state_q == PsIdle || state_q == PsMoveFwd || state_q == PsMoveBack);
`else
    logic unused_btn_block;
    assign unused_btn_block = btn_block;
    assign blocked          = 1'b0;
`endif

    player_phase_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .done       (tmr_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= PsIdle;
            health_q        <= HEALTH_W'(MAX_HEALTH);
            pos_q           <= POS_W'(START_X);
            attack_active_q <= 1'b0;
            atk_prev_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            health_q        <= health_d;
            pos_q           <= pos_d;
            attack_active_q <= (state_d == PsAttackActive);
            // Tracks the button in every match state so a press held into
            // FIGHT is not seen as a new edge.
            atk_prev_q      <= btn_attack;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d        = state_q;
        health_d       = health_q;
        pos_d          = pos_q;
        tmr_clear      = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_dec        = 1'b0;

        case (game_state)
            GsIdle, GsCountdown: begin
                state_d   = PsIdle;
                health_d  = HEALTH_W'(MAX_HEALTH);
                pos_d     = POS_W'(START_X);
                tmr_clear = 1'b1;
            end

            GsFight: begin
                if (state_q == PsDead) begin
                    state_d = PsDead;
                end else if (hit_in && state_q != PsHitstun) begin
                    if (blocked) begin
                        state_d        = PsHitstun;
                        tmr_load       = 1'b1;
                        tmr_load_value = TIMER_W'(T_HITSTUN / 2 - 1);
                        // Push back is away from the opponent.
                        pos_d = pos_step(pos_q, (SIDE != 0), 4, X_MIN, X_MAX);
                    end else begin
                        health_d = (health_q == '0) ? '0 : health_q - 1'b1;
                        if (health_d == '0) begin
                            state_d = PsDead;
                        end else begin
                            state_d        = PsHitstun;
                            tmr_load       = 1'b1;
                            tmr_load_value = TIMER_W'(T_HITSTUN - 1);
                        end
                    end
                end else begin
                    unique case (state_q)
                        PsHitstun: begin
                            if (tmr_done) state_d = PsIdle;
                            else          tmr_dec = 1'b1;
                        end
                        PsAttackWindup: begin
                            if (tmr_done) begin
                                state_d        = PsAttackActive;
                                tmr_load       = 1'b1;
                                tmr_load_value = TIMER_W'(T_ACTIVE - 1);
                            end else begin
                                tmr_dec = 1'b1;
                            end
                        end
                        PsAttackActive: begin
                            if (tmr_done) begin
                                state_d        = PsAttackRecover;
                                tmr_load       = 1'b1;
                                tmr_load_value = TIMER_W'(T_RECOVER - 1);
                            end else begin
                                tmr_dec = 1'b1;
                            end
                        end
                        PsAttackRecover: begin
                            if (tmr_done) state_d = PsIdle;
                            else          tmr_dec = 1'b1;
                        end
                        PsIdle, PsMoveFwd, PsMoveBack: begin
                            if (atk_rise) begin
                                state_d        = PsAttackWindup;
                                tmr_load       = 1'b1;
                                tmr_load_value = TIMER_W'(T_WINDUP - 1);
                            end else if (btn_left ^ btn_right) begin
                                state_d = move_fwd ? PsMoveFwd : PsMoveBack;
                                pos_d   = pos_step(pos_q, btn_right, SPEED, X_MIN, X_MAX);
                            end else begin
                                state_d = PsIdle;
                            end
                        end
                        default: state_d = PsIdle;
                    endcase
                end
            end

            // P1_WIN, P2_WIN, EQ (and undefined codes): hold everything.
            default: ;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        player_state  = state_q;
        player_health = health_q;
        pos_x         = pos_q;
        attack_active = attack_active_q;
    end

endmodule

// File: tb/tb_player_fsm.sv
module tb_player_fsm;

    localparam int MAX_HEALTH = 3;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 639;
    localparam int SPEED      = 2;
    localparam int T_WINDUP   = 8;
    localparam int T_ACTIVE   = 4;
    localparam int T_RECOVER  = 12;
    localparam int T_HITSTUN  = 20;
    localparam int START0     = 100;
    localparam int START1     = 638;

    localparam int G_COUNTDOWN = 1;
    localparam int G_FIGHT     = 2;
    localparam int G_P1WIN     = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] game_state;
    logic       btn_left, btn_right, btn_attack, btn_block, hit_in;

    logic [2:0] st0, st1;
    logic [2:0] hp0, hp1;
    logic [9:0] px0, px1;
    logic       aa0, aa1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    player_fsm u_dut0 (
        .clk           (clk),
        .reset         (reset),
        .game_state    (game_state),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .btn_block     (btn_block),
        .hit_in        (hit_in),
        .player_state  (st0),
        .player_health (hp0),
        .pos_x         (px0),
        .attack_active (aa0)
    );

    player_fsm #(
        .SIDE    (1),
        .START_X (START1)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .game_state    (game_state),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .btn_block     (btn_block),
        .hit_in        (hit_in),
        .player_state  (st1),
        .player_health (hp1),
        .pos_x         (px1),
        .attack_active (aa1)
    );

    // Reference model: state code, health, position, frames left in the
    // current timed phase, and last-seen attack button.
    typedef struct {
        int st;
        int hp;
        int pos;
        int left;
        bit prev;
    } pm_t;

    pm_t m0, m1;

    function automatic int clamp(input int p);
        if (p < X_MIN) return X_MIN;
        if (p > X_MAX) return X_MAX;
        return p;
    endfunction

    function automatic pm_t step(input pm_t m, input int side, input int start_x, input int gs,
                                 input bit l, input bit r, input bit a, input bit b, input bit h);
        pm_t n;
        bit  rise;
        bit  can_block;
        n         = m;
        rise      = a && !m.prev;
        can_block = 1'b0;
`ifdef PLAYER_BLOCK_EN
        can_block = b && (m.st <= 2);
`endif
        n.prev = a;
        if (gs == 0 || gs == 1) begin
            n.st   = 0;
            n.hp   = MAX_HEALTH;
            n.pos  = start_x;
            n.left = 0;
        end else if (gs == 2) begin
            if (m.st == 7) begin
                n.st = 7;
            end else if (h && m.st != 6) begin
                if (can_block) begin
                    n.st   = 6;
                    n.left = T_HITSTUN / 2;
                    n.pos  = clamp(m.pos + (side != 0 ? 4 : -4));
                end else begin
                    n.hp = (m.hp > 0) ? m.hp - 1 : 0;
                    if (n.hp == 0) begin
                        n.st = 7;
                    end else begin
                        n.st   = 6;
                        n.left = T_HITSTUN;
                    end
                end
            end else if (m.st >= 3 && m.st <= 6) begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    if (m.st == 3) begin
                        n.st   = 4;
                        n.left = T_ACTIVE;
                    end else if (m.st == 4) begin
                        n.st   = 5;
                        n.left = T_RECOVER;
                    end else begin
                        n.st = 0;
                    end
                end
            end else if (rise) begin
                n.st   = 3;
                n.left = T_WINDUP;
            end else if (l != r) begin
                n.st  = ((side == 0) == r) ? 1 : 2;
                n.pos = clamp(m.pos + (r ? SPEED : -SPEED));
            end else begin
                n.st = 0;
            end
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input int exp);
        total++;
        assert (got === 16'(exp))
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic frame(input int gs, input bit l, input bit r, input bit a, input bit b,
                         input bit h);
        game_state = 3'(gs);
        btn_left   = l;
        btn_right  = r;
        btn_attack = a;
        btn_block  = b;
        hit_in     = h;
        @(posedge clk);
        #1;
        m0 = step(m0, 0, START0, gs, l, r, a, b, h);
        m1 = step(m1, 1, START1, gs, l, r, a, b, h);
        check("p0_state",  16'(st0), m0.st);
        check("p0_health", 16'(hp0), m0.hp);
        check("p0_pos",    16'(px0), m0.pos);
        check("p0_active", 16'(aa0), int'(m0.st == 4));
        check("p1_state",  16'(st1), m1.st);
        check("p1_health", 16'(hp1), m1.hp);
        check("p1_pos",    16'(px1), m1.pos);
        check("p1_active", 16'(aa1), int'(m1.st == 4));
    endtask

    initial begin
        int aa_count;
        reset      = 1'b1;
        game_state = 3'd0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_attack = 1'b0;
        btn_block  = 1'b0;
        hit_in     = 1'b0;
        m0 = '{st: 0, hp: MAX_HEALTH, pos: START0, left: 0, prev: 1'b0};
        m1 = '{st: 0, hp: MAX_HEALTH, pos: START1, left: 0, prev: 1'b0};

        // Asynchronous reset values, before any clock edge.
        #2;
        check("rst_state",  16'(st0), 0);
        check("rst_health", 16'(hp0), MAX_HEALTH);
        check("rst_pos0",   16'(px0), START0);
        check("rst_pos1",   16'(px1), START1);
        check("rst_active", 16'(aa0), 0);
        #10;
        reset = 1'b0;

        // Round re-arm: COUNTDOWN ignores everything.
        for (int i = 0; i < 20; i++)
            frame(G_COUNTDOWN, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));

        // Attack held across the transition into FIGHT must not fire.
        frame(G_COUNTDOWN, 0, 0, 1, 0, 0);
        frame(G_FIGHT, 0, 0, 1, 0, 0);
        check("held_no_attack", 16'(st0), 0);
        frame(G_FIGHT, 0, 0, 0, 0, 0);

        // Single press then hold: one full attack, no retrigger.
        aa_count = 0;
        for (int i = 0; i < 34; i++) begin
            frame(G_FIGHT, 0, 0, 1, 0, 0);
            if (aa0) aa_count++;
        end
        check("active_frames", 16'(aa_count), T_ACTIVE);
        check("attack_done_idle", 16'(st0), 0);
        frame(G_FIGHT, 0, 0, 0, 0, 0);

        // Three hits 25 frames apart: 3 -> 2 -> 1 -> 0 and DEAD.
        for (int k = 0; k < 3; k++) begin
            frame(G_FIGHT, 0, 0, 0, 0, 1);
            for (int i = 0; i < 24; i++) frame(G_FIGHT, 0, 0, 0, 0, 0);
        end
        check("dead_state", 16'(st0), 7);
        check("dead_health", 16'(hp0), 0);
        for (int i = 0; i < 15; i++)
            frame(G_FIGHT, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
        check("dead_absorbing", 16'(st0), 7);

        // Re-arm, then hit during windup and a second hit inside hitstun.
        for (int i = 0; i < 3; i++) frame(G_COUNTDOWN, 0, 0, 0, 0, 0);
        frame(G_FIGHT, 0, 0, 1, 0, 0);
        frame(G_FIGHT, 0, 0, 0, 0, 0);
        frame(G_FIGHT, 0, 0, 0, 0, 1);
        check("interrupt_hitstun", 16'(st0), 6);
        for (int i = 0; i < 4; i++) frame(G_FIGHT, 0, 0, 0, 0, 0);
        frame(G_FIGHT, 0, 0, 0, 0, 1);
        check("invuln_health", 16'(hp0), 2);
        for (int i = 0; i < 20; i++) frame(G_FIGHT, 0, 0, 0, 0, 0);

        // Clamp: left held until both players sit at X_MIN.
        for (int i = 0; i < 330; i++) frame(G_FIGHT, 1, 0, 0, 0, 0);
        check("clamp_p1_pos", 16'(px1), X_MIN);
        check("clamp_p1_fwd", 16'(st1), 1);
        check("clamp_p0_back", 16'(st0), 2);
        for (int i = 0; i < 4; i++) frame(G_FIGHT, 1, 1, 0, 0, 0);
        check("both_idle", 16'(st1), 0);

        // Move right up to the upper clamp.
        for (int i = 0; i < 330; i++) frame(G_FIGHT, 0, 1, 0, 0, 0);
        check("clamp_max", 16'(px0), X_MAX);

        // Freeze on a win: hits and buttons ignored.
        frame(G_FIGHT, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++)
            frame(G_P1WIN, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);

        // Block (or plain hit without the block build) from IDLE.
        for (int i = 0; i < 3; i++) frame(G_COUNTDOWN, 0, 0, 0, 0, 0);
        frame(G_FIGHT, 0, 0, 0, 1, 1);
        for (int i = 0; i < 22; i++) frame(G_FIGHT, 0, 0, 0, 1, 0);

        // Random play, mostly FIGHT with sparse hits and occasional re-arm.
        for (int i = 0; i < 800; i++) begin
            int g;
            int sel;
            sel = int'($urandom_range(99, 0));
            if (sel < 4)      g = G_COUNTDOWN;
            else if (sel < 7) g = 3 + int'($urandom_range(2, 0));
            else              g = G_FIGHT;
            frame(g, 1'($urandom), 1'($urandom), ($urandom_range(3, 0) == 0),
                  1'($urandom), ($urandom_range(15, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
